// File: rtl/uart_dbg_ctrl.sv
// uart_dbg_ctrl: UART-driven debug controller.
// Parses Read/Write/Exec command frames from a received byte stream, runs a
// single OBI access (Read/Write) or issues a one-cycle jump request (Exec), and
// answers on the TX byte stream with Ack (0x06) or Eot (0x04) plus the four
// read-data bytes, LSB first, for a successful Read.
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   rx_valid_i/rx_data_i/rx_ready_o received byte stream (valid/ready)
//   tx_valid_o/tx_data_o/tx_ready_i response byte stream (valid/ready)
//   obi_*                           OBI manager port (single outstanding access)
//   exec_valid_o/exec_addr_o        one-cycle jump request to the core
//   busy_o                          high whenever a command is in progress
module uart_dbg_ctrl #(
  parameter int unsigned TimeoutCycles = 100000,
  parameter int unsigned AddrWidth     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 rx_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [3:0]           obi_be_o,
  output logic [31:0]          obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [31:0]          obi_rdata_i,
  input  logic                 obi_err_i,
  output logic                 exec_valid_o,
  output logic [AddrWidth-1:0] exec_addr_o,
  output logic                 busy_o
);

  localparam int unsigned TimerWidth = $clog2(TimeoutCycles + 1);

  localparam logic [7:0] CmdRead  = 8'h11;
  localparam logic [7:0] CmdWrite = 8'h12;
  localparam logic [7:0] CmdExec  = 8'h13;
  localparam logic [7:0] RspAck   = 8'h06;
  localparam logic [7:0] RspEot   = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_RESP,
    ST_RDATA,
    ST_EXEC
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_READ,
    OP_WRITE,
    OP_EXEC
  } op_e;

  // Internal state
  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Registered outputs
  logic                  rx_ready_q, rx_ready_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  obi_req_q, obi_req_d;
  logic [AddrWidth-1:0]  obi_addr_q, obi_addr_d;
  logic                  obi_we_q, obi_we_d;
  logic [3:0]            obi_be_q, obi_be_d;
  logic [31:0]           obi_wdata_q, obi_wdata_d;
  logic                  exec_valid_q, exec_valid_d;
  logic [AddrWidth-1:0]  exec_addr_q, exec_addr_d;
  logic                  busy_q, busy_d;

  logic rx_fire;
  logic tx_fire;
  logic timer_expired;

  assign rx_fire       = rx_valid_i && rx_ready_q;
  assign tx_fire       = tx_valid_q && tx_ready_i;
  assign timer_expired = (timer_q >= TimerWidth'(TimeoutCycles - 1));

  // Next-state logic; registered outputs are derived from the next state so
  // they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          // Anything that is not a known opcode is silently dropped.
          unique case (rx_data_i)
            CmdRead:  op_d = OP_READ;
            CmdWrite: op_d = OP_WRITE;
            CmdExec:  op_d = OP_EXEC;
            default:  op_d = op_q;
          endcase
          if (rx_data_i inside {CmdRead, CmdWrite, CmdExec}) begin
            state_d = ST_ADDR;
            cnt_d   = 2'd0;
            timer_d = '0;
            err_d   = 1'b0;
          end
        end
      end

      ST_ADDR: begin
        if (rx_fire) begin
          addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          timer_d = '0;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            unique case (op_q)
              OP_WRITE: state_d = ST_DATA;
              OP_READ:  state_d = ST_BUS_REQ;
              OP_EXEC:  state_d = ST_EXEC;
              default:  state_d = ST_IDLE;
            endcase
          end
        end else if (timer_expired) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end

      ST_DATA: begin
        if (rx_fire) begin
          data_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          timer_d = '0;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_BUS_REQ;
          end
        end else if (timer_expired) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end

      ST_BUS_REQ: begin
        if (obi_gnt_i) begin
          state_d = ST_BUS_WAIT;
        end
      end

      // rvalid is only looked at here, so a response in the grant cycle is ignored.
      ST_BUS_WAIT: begin
        if (obi_rvalid_i) begin
          rdata_d = obi_rdata_i;
          err_d   = obi_err_i;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (tx_fire) begin
          if (op_q == OP_READ && !err_q) begin
            state_d = ST_RDATA;
            cnt_d   = 2'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RDATA: begin
        if (tx_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_IDLE;
          end
        end
      end

      // Error flag was cleared at the opcode, so the response is always Ack.
      ST_EXEC: begin
        state_d = ST_RESP;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values
  always_comb begin
    rx_ready_d   = state_d inside {ST_IDLE, ST_ADDR, ST_DATA};
    tx_valid_d   = state_d inside {ST_RESP, ST_RDATA};
    tx_data_d    = 8'h00;
    obi_req_d    = (state_d == ST_BUS_REQ);
    obi_addr_d   = obi_addr_q;
    obi_we_d     = obi_we_q;
    obi_be_d     = obi_be_q;
    obi_wdata_d  = obi_wdata_q;
    exec_valid_d = (state_d == ST_EXEC);
    exec_addr_d  = exec_addr_q;
    busy_d       = (state_d != ST_IDLE);

    if (state_d == ST_RESP) begin
      tx_data_d = err_d ? RspEot : RspAck;
    end else if (state_d == ST_RDATA) begin
      tx_data_d = rdata_d[{cnt_d, 3'b000} +: 8];
    end

    // Bus payload is loaded on the way into BUS_REQ and held stable after.
    if (state_d == ST_BUS_REQ) begin
      obi_addr_d  = AddrWidth'(addr_d);
      obi_we_d    = (op_d == OP_WRITE);
      obi_be_d    = 4'hF;
      obi_wdata_d = data_d;
    end

    if (state_d == ST_EXEC) begin
      exec_addr_d = AddrWidth'(addr_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NONE;
      cnt_q        <= 2'd0;
      timer_q      <= '0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      rx_ready_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      obi_req_q    <= 1'b0;
      obi_addr_q   <= '0;
      obi_we_q     <= 1'b0;
      obi_be_q     <= 4'h0;
      obi_wdata_q  <= 32'h0;
      exec_valid_q <= 1'b0;
      exec_addr_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      rx_ready_q   <= rx_ready_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      obi_req_q    <= obi_req_d;
      obi_addr_q   <= obi_addr_d;
      obi_we_q     <= obi_we_d;
      obi_be_q     <= obi_be_d;
      obi_wdata_q  <= obi_wdata_d;
      exec_valid_q <= exec_valid_d;
      exec_addr_q  <= exec_addr_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_ready_o   = rx_ready_q;
  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;
  assign obi_req_o    = obi_req_q;
  assign obi_addr_o   = obi_addr_q;
  assign obi_we_o     = obi_we_q;
  assign obi_be_o     = obi_be_q;
  assign obi_wdata_o  = obi_wdata_q;
  assign exec_valid_o = exec_valid_q;
  assign exec_addr_o  = exec_addr_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
// tb_uart_dbg_ctrl: self-checking bench for uart_dbg_ctrl.
// Drives command frames on the RX stream, plays an OBI subordinate with random
// grant/response delays and random TX back-pressure, and compares the logged
// OBI accesses, TX bytes and exec pulses against a command-level model.
module tb_uart_dbg_ctrl;

  localparam int unsigned TO = 40;
  localparam int unsigned AW = 32;
  localparam int OP_RD = 0;
  localparam int OP_WR = 1;
  localparam int OP_EX = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          rx_ready_o;
  logic          tx_valid_o;
  logic [7:0]    tx_data_o;
  logic          tx_ready_i;
  logic          obi_req_o;
  logic          obi_gnt_i;
  logic [AW-1:0] obi_addr_o;
  logic          obi_we_o;
  logic [3:0]    obi_be_o;
  logic [31:0]   obi_wdata_o;
  logic          obi_rvalid_i;
  logic [31:0]   obi_rdata_i;
  logic          obi_err_i;
  logic          exec_valid_o;
  logic [AW-1:0] exec_addr_o;
  logic          busy_o;

  uart_dbg_ctrl #(.TimeoutCycles(TO), .AddrWidth(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .exec_valid_o(exec_valid_o), .exec_addr_o(exec_addr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_txn_t;

  int n_tests = 0;
  int n_fail  = 0;

  obi_txn_t    obi_log[$];
  logic [7:0]  tx_log[$];
  logic [31:0] exec_log[$];
  int          hold_viol = 0;
  int          req_seen  = 0;
  int          ack_lat   = -1;

  logic [31:0] cur_rdata = 32'h0;
  logic        cur_err   = 1'b0;
  bit          gnt_hold  = 1'b0;
  int          tx_rate   = 60;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: logs handshakes and checks that stalled payloads stay put
  initial begin
    int          cyc = 0;
    int          rv_cyc = 0;
    bit          ack_wait = 0;
    bit          p_txv = 0, p_txr = 0, p_req = 0, p_gnt = 0;
    logic [7:0]  p_txd = 8'h0;
    logic [68:0] p_bus = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        p_txv = 0; p_req = 0; ack_wait = 0;
      end else begin
        if (p_txv && !p_txr && (!tx_valid_o || tx_data_o != p_txd)) hold_viol++;
        if (p_req && !p_gnt &&
            (!obi_req_o || {obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o} != p_bus)) hold_viol++;
        if (obi_req_o) req_seen++;
        if (obi_req_o && obi_gnt_i) obi_log.push_back('{obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o});
        if (tx_valid_o && tx_ready_i) tx_log.push_back(tx_data_o);
        if (exec_valid_o) exec_log.push_back(exec_addr_o);
        if (obi_rvalid_i) begin
          rv_cyc = cyc; ack_wait = 1;
        end else if (ack_wait && tx_valid_o) begin
          ack_lat = cyc - rv_cyc; ack_wait = 0;
        end
        p_txv = tx_valid_o; p_txr = tx_ready_i; p_txd = tx_data_o;
        p_req = obi_req_o; p_gnt = obi_gnt_i;
        p_bus = {obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o};
      end
    end
  end

  // OBI subordinate: random grant delay, response 1..3 cycles after grant.
  // A bogus rvalid is sometimes shown in the grant cycle; it must be ignored.
  initial begin
    int rv_left = 0;
    obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0; obi_err_i = 0;
    forever begin
      tick();
      obi_gnt_i = 0; obi_rvalid_i = 0;
      obi_rdata_i = $urandom; obi_err_i = 1'($urandom_range(0, 1));
      if (!rst_ni) begin
        rv_left = 0;
      end else if (rv_left > 0) begin
        rv_left--;
        if (rv_left == 0) begin
          obi_rvalid_i = 1; obi_rdata_i = cur_rdata; obi_err_i = cur_err;
        end
      end else if (obi_req_o && !gnt_hold && $urandom_range(0, 2) == 0) begin
        obi_gnt_i = 1;
        rv_left = $urandom_range(1, 3);
        if ($urandom_range(0, 1) == 1) begin
          obi_rvalid_i = 1; obi_rdata_i = ~cur_rdata; obi_err_i = ~cur_err;
        end
      end
    end
  end

  // TX back-pressure
  initial begin
    tx_ready_i = 0;
    forever begin
      tick();
      tx_ready_i = ($urandom_range(0, 99) < tx_rate);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid_i = 1; rx_data_i = b;
    @(negedge clk_i);
    while (!rx_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("rx_accept", 32'(rx_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rx_valid_i = 0;
  endtask

  task automatic clear_logs();
    obi_log.delete(); tx_log.delete(); exec_log.delete();
    ack_lat = -1; req_seen = 0;
  endtask

  task automatic send_frame(input int op, input logic [31:0] addr, input logic [31:0] data,
                            input bit garbage, input int gmin, input int gmax);
    logic [7:0] frame[$];
    logic [7:0] b;
    if (garbage) begin
      do b = 8'($urandom); while (b inside {8'h11, 8'h12, 8'h13});
      frame.push_back(b);
    end
    frame.push_back(8'h11 + 8'(op));
    for (int i = 0; i < 4; i++) frame.push_back(addr[8*i +: 8]);
    if (op == OP_WR) for (int i = 0; i < 4; i++) frame.push_back(data[8*i +: 8]);
    foreach (frame[i]) begin
      repeat ($urandom_range(gmin, gmax)) tick();
      send_byte(frame[i]);
    end
  endtask

  task automatic run_cmd(input int op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input logic err, input bit garbage,
                         input int gmin, input int gmax);
    logic [7:0] exp_tx[$];
    int n = 0;
    clear_logs();
    cur_rdata = rdata; cur_err = err;
    send_frame(op, addr, data, garbage, gmin, gmax);
    if (op != OP_EX) chk("req_latency", 32'(obi_req_o), 32'd1);
    while (busy_o && n < 2000) begin
      tick();
      n++;
    end
    chk("cmd_done", 32'(busy_o), 32'd0);
    repeat (2) tick();

    // Model: what one command must produce
    if (op == OP_EX || !err) exp_tx.push_back(8'h06);
    else exp_tx.push_back(8'h04);
    if (op == OP_RD && !err) for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);

    chk("obi_count", 32'(obi_log.size()), (op == OP_EX) ? 32'd0 : 32'd1);
    if (op != OP_EX && obi_log.size() > 0) begin
      chk("obi_addr", obi_log[0].addr, addr);
      chk("obi_we", 32'(obi_log[0].we), (op == OP_WR) ? 32'd1 : 32'd0);
      chk("obi_be", 32'(obi_log[0].be), 32'hF);
      if (op == OP_WR) chk("obi_wdata", obi_log[0].wdata, data);
      chk("ack_latency", 32'(ack_lat), 32'd1);
    end
    chk("tx_count", 32'(tx_log.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk($sformatf("tx_byte%0d", i), 32'(tx_log[i]), 32'(exp_tx[i]));
    chk("exec_count", 32'(exec_log.size()), (op == OP_EX) ? 32'd1 : 32'd0);
    if (op == OP_EX && exec_log.size() > 0) chk("exec_addr", exec_log[0], addr);
  endtask

  initial begin
    int n;
    rx_valid_i = 0; rx_data_i = 0;
    repeat (3) tick();
    chk("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_obi_req", 32'(obi_req_o), 32'd0);
    chk("rst_obi_we", 32'(obi_we_o), 32'd0);
    chk("rst_obi_addr", 32'(obi_addr_o), 32'd0);
    chk("rst_obi_wdata", obi_wdata_o, 32'd0);
    chk("rst_obi_be", 32'(obi_be_o), 32'd0);
    chk("rst_exec_valid", 32'(exec_valid_o), 32'd0);
    chk("rst_exec_addr", 32'(exec_addr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1;
    tick();
    chk("post_rst_rx_ready", 32'(rx_ready_o), 32'd1);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // Directed: write, read, errors, exec
    tx_rate = 70;
    run_cmd(OP_WR, 32'h1000_0000, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 0, 2);
    tx_rate = 50;
    run_cmd(OP_RD, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 2);
    run_cmd(OP_WR, 32'h2000_0010, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0, 0, 2);
    run_cmd(OP_RD, 32'h2000_0014, 32'h0, 32'h0BAD_0BAD, 1'b1, 1'b0, 0, 2);
    run_cmd(OP_EX, 32'h1000_0080, 32'h0, 32'h0, 1'b0, 1'b0, 0, 2);
    // Inter-byte gaps just under the timeout must not abort the frame
    run_cmd(OP_RD, 32'h3000_0000, 32'h0, 32'h8765_4321, 1'b0, 1'b1, TO - 2, TO - 2);

    // Garbage byte then a stalled partial Read: dropped, timed out, no access
    clear_logs();
    send_byte(8'h55);
    chk("garbage_idle", 32'(busy_o), 32'd0);
    send_byte(8'h11);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("partial_busy", 32'(busy_o), 32'd1);
    repeat (TO + 10) tick();
    chk("timeout_idle", 32'(busy_o), 32'd0);
    chk("timeout_no_req", 32'(req_seen), 32'd0);
    chk("timeout_no_tx", 32'(tx_log.size()), 32'd0);
    run_cmd(OP_RD, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 2);

    // Reset while a Write is stuck in BUS_REQ
    clear_logs();
    gnt_hold = 1;
    send_frame(OP_WR, 32'h4000_0000, 32'h1111_2222, 1'b0, 0, 1);
    repeat (5) tick();
    chk("stuck_req", 32'(obi_req_o), 32'd1);
    #2;
    rst_ni = 0;
    #1;
    chk("async_rst_req", 32'(obi_req_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_txv", 32'(tx_valid_o), 32'd0);
    repeat (2) tick();
    @(negedge clk_i);
    rst_ni = 1;
    gnt_hold = 0;
    repeat (2) tick();
    chk("post_abort_req", 32'(obi_req_o), 32'd0);
    chk("post_abort_txn", 32'(obi_log.size()), 32'd0);
    run_cmd(OP_WR, 32'h4000_0008, 32'h3333_4444, 32'h0, 1'b0, 1'b0, 0, 2);

    // Randomized command mix
    for (int k = 0; k < 40; k++) begin
      tx_rate = $urandom_range(20, 100);
      run_cmd($urandom_range(0, 2), $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0, 3);
    end

    n = hold_viol;
    chk("handshake_hold", 32'(n), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
